// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - single-issue IDLE/EXEC/WB controller driving a registered 8-bit ALU
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [17:0] in_instr,
    output logic        in_ready,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_operand,
    input  logic [7:0]  alu_y,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic        res_zero,
    output logic        res_err,
    output logic        busy,
    input  logic [1:0]  dbg_sel,
    output logic [7:0]  dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [17:0] r_instr;
    logic [7:0]  r_regs [4];

    logic [3:0]  w_op;
    logic [1:0]  w_rd;
    logic [1:0]  w_ra;
    logic [1:0]  w_rb;
    logic        w_imm;
    logic        w_operand;
    logic [7:0]  w_imm8;
    logic        w_nop;
    logic        w_illegal;
    logic        w_legal;
    logic        w_accept;
    logic        w_wb_write;
    logic [7:0]  w_src_a;
    logic [7:0]  w_src_b;

    assign w_op      = r_instr[17:14];
    assign w_rd      = r_instr[13:12];
    assign w_ra      = r_instr[11:10];
    assign w_imm     = r_instr[9];
    assign w_operand = r_instr[8];
    assign w_imm8    = r_instr[7:0];
    assign w_rb      = r_instr[1:0];

    assign w_nop     = (w_op == OP_NOP);
    assign w_illegal = (w_op == 4'h9) || (w_op == 4'hE) || (w_op == 4'hF);
    assign w_legal   = !w_nop && !w_illegal;

    // The register file is written at the WB edge, so a following EXEC reads
    // the fresh value straight from r_regs with no bypass path needed.
    assign w_src_a   = r_regs[w_ra];
    assign w_src_b   = w_imm ? w_imm8 : r_regs[w_rb];

    assign w_accept   = in_valid && in_ready;
    assign w_wb_write = (r_state == S_WB) && w_legal;

    assign dbg_data   = r_regs[dbg_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= '0;
        end else if (w_accept) begin
            r_instr <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_wb_write) begin
            r_regs[w_rd] <= alu_y;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        alu_op      = OP_NOP;
        alu_a       = 8'h00;
        alu_b       = 8'h00;
        alu_operand = 1'b0;
        res_valid   = 1'b0;
        res_data    = 8'h00;
        res_zero    = 1'b0;
        res_err     = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                // NOP and illegal ops leave alu_op at 0 so the ALU returns 0 in WB.
                if (w_legal) begin
                    alu_op      = w_op;
                    alu_operand = w_operand;
                    alu_a       = w_src_a;
                    alu_b       = w_src_b;
                end
                w_state_nxt = S_WB;
            end
            S_WB: begin
                in_ready  = 1'b1;
                res_valid = 1'b1;
                res_data  = alu_y;
                res_zero  = (alu_y == 8'h00);
                res_err   = w_illegal;
                w_state_nxt = in_valid ? S_EXEC : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed vector bench for alu_sequencer with a registered ALU model
module tb_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [17:0] in_instr;
    logic        in_ready;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic        alu_operand;
    logic [7:0]  alu_y;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_zero;
    logic        res_err;
    logic        busy;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int n_cmp;
    int n_fail;

    alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_operand (alu_operand),
        .alu_y       (alu_y),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_zero    (res_zero),
        .res_err     (res_err),
        .busy        (busy),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic sel);
        logic [7:0] src;
        src = sel ? b : a;
        case (op)
            4'h1: alu_f = a + b;
            4'h2: alu_f = a - b;
            4'h3: alu_f = {src[6:0], 1'b0};
            4'h4: alu_f = {1'b0, src[7:1]};
            4'h5: alu_f = a & b;
            4'h6: alu_f = a | b;
            4'h7: alu_f = a ^ b;
            4'h8: alu_f = ~src;
            4'hA: alu_f = b;
            4'hB: alu_f = {7'd0, a < b};
            4'hC: alu_f = {7'd0, a == b};
            4'hD: alu_f = {7'd0, a > b};
            default: alu_f = 8'h00;
        endcase
    endfunction

    logic alu_rstn;
    assign alu_rstn = ~rst;

    always @(posedge clk) begin
        if (!alu_rstn) alu_y <= 8'h00;
        else           alu_y <= alu_f(alu_op, alu_a, alu_b, alu_operand);
    end

    function automatic logic [17:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic imm,
                                       input logic opnd, input logic [7:0] low);
        mk = {op, rd, ra, imm, opnd, low};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [17:0] instr;
        logic [7:0]  exp_data;
        logic        exp_zero;
        logic        exp_err;
        logic [1:0]  chk_reg;
        logic [7:0]  exp_reg;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic run_vec(input int i);
        int  lat;
        bit  seen;
        @(negedge clk);
        in_instr = vecs[i].instr;
        in_valid = 1'b1;
        dbg_sel  = vecs[i].chk_reg;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            if (res_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check($sformatf("v%0d res_valid seen", i), 32'(seen), 32'd1);
        check($sformatf("v%0d latency", i), 32'(lat), 32'd2);
        check($sformatf("v%0d res_data", i), 32'(res_data), 32'(vecs[i].exp_data));
        check($sformatf("v%0d res_zero", i), 32'(res_zero), 32'(vecs[i].exp_zero));
        check($sformatf("v%0d res_err", i), 32'(res_err), 32'(vecs[i].exp_err));
        @(negedge clk);
        check($sformatf("v%0d reg r%0d", i, vecs[i].chk_reg), 32'(dbg_data), 32'(vecs[i].exp_reg));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        dbg_sel  = 2'd0;

        vecs[0]  = '{mk(4'hA, 2'd1, 2'd0, 1'b1, 1'b0, 8'h7F), 8'h7F, 1'b0, 1'b0, 2'd1, 8'h7F};
        vecs[1]  = '{mk(4'h1, 2'd2, 2'd1, 1'b1, 1'b0, 8'h01), 8'h80, 1'b0, 1'b0, 2'd2, 8'h80};
        vecs[2]  = '{mk(4'h2, 2'd0, 2'd0, 1'b1, 1'b0, 8'h01), 8'hFF, 1'b0, 1'b0, 2'd0, 8'hFF};
        vecs[3]  = '{mk(4'hC, 2'd3, 2'd0, 1'b1, 1'b0, 8'hFF), 8'h01, 1'b0, 1'b0, 2'd3, 8'h01};
        vecs[4]  = '{mk(4'hE, 2'd2, 2'd1, 1'b1, 1'b0, 8'h33), 8'h00, 1'b1, 1'b1, 2'd2, 8'h80};
        vecs[5]  = '{mk(4'hA, 2'd1, 2'd0, 1'b1, 1'b0, 8'h0F), 8'h0F, 1'b0, 1'b0, 2'd1, 8'h0F};
        vecs[6]  = '{mk(4'h8, 2'd3, 2'd0, 1'b0, 1'b1, 8'h01), 8'hF0, 1'b0, 1'b0, 2'd3, 8'hF0};
        vecs[7]  = '{mk(4'h7, 2'd0, 2'd1, 1'b0, 1'b0, 8'h01), 8'h00, 1'b1, 1'b0, 2'd0, 8'h00};
        vecs[8]  = '{mk(4'h0, 2'd1, 2'd2, 1'b1, 1'b0, 8'h55), 8'h00, 1'b1, 1'b0, 2'd1, 8'h0F};
        vecs[9]  = '{mk(4'h4, 2'd2, 2'd2, 1'b0, 1'b0, 8'h00), 8'h40, 1'b0, 1'b0, 2'd2, 8'h40};
        vecs[10] = '{mk(4'hB, 2'd3, 2'd0, 1'b1, 1'b0, 8'h01), 8'h01, 1'b0, 1'b0, 2'd3, 8'h01};
        vecs[11] = '{mk(4'hD, 2'd3, 2'd2, 1'b1, 1'b0, 8'h50), 8'h00, 1'b1, 1'b0, 2'd3, 8'h00};
        vecs[12] = '{mk(4'h1, 2'd2, 2'd2, 1'b1, 1'b0, 8'hF0), 8'h30, 1'b0, 1'b0, 2'd2, 8'h30};
        vecs[13] = '{mk(4'h5, 2'd1, 2'd2, 1'b1, 1'b0, 8'h21), 8'h20, 1'b0, 1'b0, 2'd1, 8'h20};
        vecs[14] = '{mk(4'h6, 2'd0, 2'd1, 1'b1, 1'b0, 8'h05), 8'h25, 1'b0, 1'b0, 2'd0, 8'h25};
        vecs[15] = '{mk(4'h9, 2'd0, 2'd1, 1'b1, 1'b0, 8'h05), 8'h00, 1'b1, 1'b1, 2'd0, 8'h25};
        vecs[16] = '{mk(4'hF, 2'd1, 2'd1, 1'b1, 1'b0, 8'h05), 8'h00, 1'b1, 1'b1, 2'd1, 8'h20};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset res_data", 32'(res_data), 32'd0);
        check("reset res_zero/err", 32'({res_zero, res_err}), 32'd0);
        check("reset alu outputs", 32'({alu_op, alu_a, alu_b, alu_operand}), 32'd0);
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r);
            #1;
            check($sformatf("reset reg r%0d", r), 32'(dbg_data), 32'd0);
        end

        for (int i = 0; i < NV; i++) run_vec(i);

        // Back-to-back with in_valid held: LOAD r1<-05 then SHL r1 must see 05.
        @(negedge clk);
        dbg_sel  = 2'd1;
        in_instr = mk(4'hA, 2'd1, 2'd0, 1'b1, 1'b0, 8'h05);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_instr = mk(4'h3, 2'd1, 2'd1, 1'b0, 1'b0, 8'h00);
        check("b2b exec in_ready", 32'(in_ready), 32'd0);
        check("b2b exec busy", 32'(busy), 32'd1);
        check("b2b exec alu_op", 32'(alu_op), 32'hA);
        @(negedge clk);
        check("b2b wb1 res_valid", 32'(res_valid), 32'd1);
        check("b2b wb1 res_data", 32'(res_data), 32'h05);
        check("b2b wb1 in_ready", 32'(in_ready), 32'd1);
        pulses = 1;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b exec2 res_valid", 32'(res_valid), 32'd0);
        check("b2b exec2 alu_a fwd", 32'(alu_a), 32'h05);
        check("b2b exec2 alu_op", 32'(alu_op), 32'h3);
        @(negedge clk);
        if (res_valid) pulses++;
        check("b2b wb2 pulse", 32'(pulses), 32'd2);
        check("b2b wb2 res_data", 32'(res_data), 32'h0A);
        @(negedge clk);
        check("b2b r1 final", 32'(dbg_data), 32'h0A);
        check("b2b idle res_valid", 32'(res_valid), 32'd0);

        // Reset during EXEC of ADD r3 = r1 + 1: no result, everything cleared.
        @(negedge clk);
        in_instr = mk(4'h1, 2'd3, 2'd1, 1'b1, 1'b0, 8'h01);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst-exec busy before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst-exec res_valid", 32'(res_valid), 32'd0);
        check("rst-exec busy", 32'(busy), 32'd0);
        check("rst-exec in_ready", 32'(in_ready), 32'd1);
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r);
            #1;
            check($sformatf("rst-exec reg r%0d", r), 32'(dbg_data), 32'd0);
        end
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (res_valid) pulses++;
        end
        check("rst-exec no late pulse", 32'(pulses), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
